// File: rtl/shift_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_ctrl
// Brief    : Universal shift register (hold / shift left / shift right /
//            parallel load) with a built-in LSB-first serializer FSM that
//            raises busy while shifting and pulses done after the last bit.
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    // Bit counter only has to reach WIDTH-1, so ceil(log2(WIDTH)) bits suffice.
    localparam int              CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] C_MODE_HOLD  = 2'b00;
    localparam logic [1:0] C_MODE_LEFT  = 2'b01;
    localparam logic [1:0] C_MODE_RIGHT = 2'b10;
    localparam logic [1:0] C_MODE_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;

    // State, data and bit-counter registers; reset aborts any transfer at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: start beats mode in IDLE/DONE; SHIFT ignores both.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_q_nxt     = d;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end else begin
                    case (mode)
                        C_MODE_HOLD:  w_q_nxt = r_q;
                        C_MODE_LEFT:  w_q_nxt = {r_q[WIDTH-2:0], sin_l};
                        C_MODE_RIGHT: w_q_nxt = {sin_r, r_q[WIDTH-1:1]};
                        C_MODE_LOAD:  w_q_nxt = d;
                        default:      w_q_nxt = r_q;
                    endcase
                end
            end
            S_SHIFT: begin
                w_q_nxt = {sin_r, r_q[WIDTH-1:1]};
                // Counter parks at the last index rather than wrapping.
                if (r_cnt == C_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DONE: begin
                // q holds here; a new start chains the next word with no gap.
                if (start) begin
                    w_q_nxt     = d;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Flags come straight from the registered state so they never glitch.
    assign q    = r_q;
    assign sout = r_q[0];
    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: doc/shift_reg_ctrl.md
# shift_reg_ctrl

Edge-triggered universal shift register with a built-in serializer FSM. It is the register stage built on top of the gated-latch storage cells in the Part 1 datapath, and the first block in that datapath with real clocked control. In manual mode it holds, shifts left, shifts right or parallel-loads every cycle. On `start` it loads a word and shifts it out LSB-first on `sout`, with `busy`/`done` handshake flags.

## Interface
- WIDTH, 8, register width in bits; legal range 2..32.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  2  manual operation in IDLE:
  - 00 hold
  - 01 shift left
  - 10 shift right
  - 11 parallel load
- d  in  WIDTH  parallel load data, used by mode 11 and by `start`.
- sin_l  in  1  fill bit entering at bit 0 on a shift left.
- sin_r  in  1  fill bit entering at bit WIDTH-1 on a shift right or a serializer shift.
- start  in  1  request to serialize `d`; single-cycle or level.
- q  out  WIDTH  register contents.
- sout  out  1  serial output, combinationally equal to q[0].
- busy  out  1  high while the serializer is shifting.
- done  out  1  one-cycle pulse after the last serial bit.

## Operation
- All state is updated on the rising clk edge. rst_n low asynchronously forces the following, regardless of clk:
  - q = 0, so sout = 0
  - state = IDLE
  - bit counter cnt = 0
  - busy = 0, done = 0
- Internal state:
  - States: IDLE, SHIFT, DONE; 2-bit encoding.
  - cnt is ceil(log2(WIDTH)) bits wide, unsigned, and counts 0..WIDTH-1 without wrapping past WIDTH-1.
- IDLE:
  - start=1 takes priority over mode: q<=d, cnt<=0, go to SHIFT.
  - Otherwise mode applies:
    - 00: q<=q
    - 01: q<={q[WIDTH-2:0], sin_l}
    - 10: q<={sin_r, q[WIDTH-1:1]}
    - 11: q<=d
- SHIFT:
  - Every edge: q<={sin_r, q[WIDTH-1:1]} and cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1, go to DONE instead of incrementing.
  - mode and start are ignored.
- DONE:
  - Lasts exactly one cycle; q holds and mode is ignored.
  - start=1: behaves exactly as start in IDLE (back-to-back transfer, q<=d, cnt<=0, go to SHIFT).
  - start=0: go to IDLE.
- Outputs:
  - busy = (state==SHIFT)
  - done = (state==DONE)
  - Both are decoded from the registered state, so they are glitch-free and change only after clk edges or on reset.
- Reset asserted mid-transfer aborts it immediately. The partially shifted q is lost (q=0), no done pulse is produced, and the block is in IDLE when rst_n releases.

## Timing
- Edge E0 samples start=1 in IDLE. After E0:
  - q=d, busy=1, sout=d[0].
- Bit presentation:
  - Bit d[k] is on sout during the cycle after edge E(k), for k=0..WIDTH-1, i.e. one bit per cycle for WIDTH cycles.
  - busy is high for exactly WIDTH cycles.
- Edge E(WIDTH) enters DONE:
  - done=1 for one cycle, busy=0.
  - q now contains WIDTH copies of the sin_r values sampled at each shift edge.
- Start-to-done latency is WIDTH+1 edges.
- Back-to-back throughput is one word per WIDTH+1 cycles.
- Manual modes have 1-cycle latency: the new q is visible after the edge that samples mode.
- rst_n deassertion is asynchronous to clk. The first edge after release acts on IDLE.

## Test plan
- Reset mid-operation:
  - Stimulus: start with d=8'hA5, then assert rst_n low after 3 shift cycles, for 1 cycle.
  - Required: q=0, busy=0, done=0 immediately (before the next edge); no done pulse follows; IDLE afterwards.
- Manual modes (WIDTH=8):
  - mode=11 with d=8'h81 gives q=8'h81.
  - mode=01 with sin_l=0 gives 8'h02.
  - mode=10 with sin_r=1 gives 8'h81.
  - mode=00 for 3 cycles leaves q=8'h81.
- Serializer:
  - Stimulus: d=8'hB4, sin_r=0, one-cycle start pulse.
  - Required: sout sequence 0,0,1,0,1,1,0,1 on 8 consecutive cycles with busy=1; then done=1 for 1 cycle with q=8'h00; then IDLE with busy=0.
- Priority and ignore:
  - In IDLE, start=1 with mode=01 performs a load, not a shift.
  - During SHIFT, start=1 and mode=11 with a new d have no effect; the transfer still completes after 8 bits.
- Back-to-back:
  - Stimulus: start held high with d=8'h0F and then 8'hF0, as a second start asserted in the DONE cycle.
  - Required: the second word's shifting begins on the edge after DONE with no IDLE gap; sout stream is 1,1,1,1,0,0,0,0 then 0,0,0,0,1,1,1,1; done pulses twice, 9 cycles apart.
- Fill bit:
  - Stimulus: sin_r=1 throughout a transfer of d=8'h00.
  - Required: sout all 0 for 8 cycles, and q=8'hFF in the DONE cycle.
